// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status bundle between decode and the register scoreboard.
// The master side drives requests; the slave (scoreboard) answers with stall and status.
interface reg_scoreboard_if;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic [4:0]  issue_rd;
   logic        issue_accept;
   logic        reg_stall;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic        flush;
   logic        drain_req;
   logic        drain_done;
   logic [31:0] busy;
   logic [6:0]  inflight;
   logic        err;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_rd, wb_valid, wb_reg, flush, drain_req,
      input  issue_accept, reg_stall, drain_done, busy, inflight, err
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_rd, wb_valid, wb_reg, flush, drain_req,
      output issue_accept, reg_stall, drain_done, busy, inflight, err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: 2-bit pending-write counters per register with RAW stall,
// flush, sticky underflow error and a run/drain/done FSM.
module reg_scoreboard (
   input  logic            clock,
   input  logic            reset,
   reg_scoreboard_if.slave sb
);
   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q [32];
   logic [1:0]  cnt_d [32];
   logic [6:0]  inflight_q, inflight_d;
   logic        err_q, err_d;
   logic        drain_done_q, drain_done_d;
   logic        rs_hit, rt_hit, rd_full, stall, accept;
   logic [31:0] busy;

   always_comb begin
      rs_hit  = (sb.issue_rs != 5'd0) && (cnt_q[sb.issue_rs] != 2'd0);
      rt_hit  = (sb.issue_rt != 5'd0) && (cnt_q[sb.issue_rt] != 2'd0);
      rd_full = (sb.issue_rd != 5'd0) && (cnt_q[sb.issue_rd] == 2'd3);
      stall   = sb.issue_valid && (rs_hit || rt_hit || rd_full || (state_q != RUN));
      // reset gating keeps accept low while the async reset is held
      accept  = sb.issue_valid && !stall && !sb.flush && !reset;
   end

   always_comb begin
      err_d = err_q;
      if (sb.wb_valid && (sb.wb_reg != 5'd0) && (cnt_q[sb.wb_reg] == 2'd0))
         err_d = 1'b1;
      inflight_d = 7'd0;
      for (int n = 0; n < 32; n++) begin
         cnt_d[n] = cnt_q[n];
         if (n == 0 || sb.flush) begin
            cnt_d[n] = 2'd0;
         end else begin
            if (accept && (sb.issue_rd == 5'(n)))
               cnt_d[n] = cnt_d[n] + 2'd1;
            if (sb.wb_valid && (sb.wb_reg == 5'(n)) && (cnt_q[n] != 2'd0))
               cnt_d[n] = cnt_d[n] - 2'd1;
         end
         inflight_d = inflight_d + 7'(cnt_d[n]);
      end
   end

   // Drain completion looks at next-cycle inflight so a final writeback ends it immediately
   always_comb begin
      state_d      = state_q;
      drain_done_d = 1'b0;
      case (state_q)
         RUN:   if (sb.drain_req) state_d = DRAIN;
         DRAIN: if (inflight_d == 7'd0) begin
                   state_d      = DONE;
                   drain_done_d = 1'b1;
                end
         DONE:  if (!sb.drain_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         inflight_q   <= 7'd0;
         err_q        <= 1'b0;
         drain_done_q <= 1'b0;
         for (int n = 0; n < 32; n++) cnt_q[n] <= 2'd0;
      end else begin
         state_q      <= state_d;
         inflight_q   <= inflight_d;
         err_q        <= err_d;
         drain_done_q <= drain_done_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      for (int n = 0; n < 32; n++) busy[n] = (cnt_q[n] != 2'd0);
   end

   assign sb.issue_accept = accept;
   assign sb.reg_stall    = stall;
   assign sb.drain_done   = drain_done_q;
   assign sb.busy         = busy;
   assign sb.inflight     = inflight_q;
   assign sb.err          = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change on the falling edge and
// outputs are checked 1ns later, so registered values reflect the previous rising edge.
module tb_reg_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec  = 0;
   int   miss = 0;
   int   rds [5] = '{1, 2, 3, 4, 8};

   reg_scoreboard_if sb_if ();

   reg_scoreboard dut (
      .clock (clk),
      .reset (rst),
      .sb    (sb_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      sb_if.issue_valid = 1'b0;
      sb_if.issue_rs    = 5'd0;
      sb_if.issue_rt    = 5'd0;
      sb_if.issue_rd    = 5'd0;
      sb_if.wb_valid    = 1'b0;
      sb_if.wb_reg      = 5'd0;
      sb_if.flush       = 1'b0;
      sb_if.drain_req   = 1'b0;
   endtask

   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      sb_if.issue_valid = v;
      sb_if.issue_rs    = rs;
      sb_if.issue_rt    = rt;
      sb_if.issue_rd    = rd;
   endtask

   task automatic wb(input logic v, input logic [4:0] r);
      sb_if.wb_valid = v;
      sb_if.wb_reg   = r;
   endtask

   initial begin
      idle();
      // reset state, accept held low under reset
      @(negedge clk); drv(1, 0, 0, 4); #1;
      chk("rst_accept",   32'(sb_if.issue_accept), 32'd0);
      chk("rst_busy",     sb_if.busy, 32'd0);
      chk("rst_inflight", 32'(sb_if.inflight), 32'd0);
      chk("rst_err",      32'(sb_if.err), 32'd0);
      chk("rst_done",     32'(sb_if.drain_done), 32'd0);
      @(negedge clk); idle(); rst = 1'b0;

      // RAW hazard on r5, no forwarding
      @(negedge clk); drv(1, 1, 2, 5); #1;
      chk("a_acc0",   32'(sb_if.issue_accept), 32'd1);
      chk("a_stall0", 32'(sb_if.reg_stall), 32'd0);
      @(negedge clk); drv(1, 5, 0, 6); #1;
      chk("a_infl1",  32'(sb_if.inflight), 32'd1);
      chk("a_busy5",  sb_if.busy, 32'h20);
      chk("a_stall1", 32'(sb_if.reg_stall), 32'd1);
      chk("a_acc1",   32'(sb_if.issue_accept), 32'd0);
      @(negedge clk); wb(1, 5); #1;
      chk("a_nofwd_stall", 32'(sb_if.reg_stall), 32'd1);
      chk("a_nofwd_acc",   32'(sb_if.issue_accept), 32'd0);
      @(negedge clk); wb(0, 0); #1;
      chk("a_busy_clr", sb_if.busy, 32'd0);
      chk("a_stall2",   32'(sb_if.reg_stall), 32'd0);
      chk("a_acc2",     32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); sb_if.issue_valid = 1'b0; wb(1, 6); #1;
      chk("a_busy6",  sb_if.busy, 32'h40);
      chk("a_infl6",  32'(sb_if.inflight), 32'd1);
      @(negedge clk); wb(0, 0); #1;
      chk("a_infl0",  32'(sb_if.inflight), 32'd0);

      // counter saturation on r7
      @(negedge clk); drv(1, 0, 0, 7); #1;
      chk("b_acc1", 32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); #1;
      chk("b_acc2", 32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); #1;
      chk("b_acc3", 32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); #1;
      chk("b_infl3", 32'(sb_if.inflight), 32'd3);
      chk("b_stall", 32'(sb_if.reg_stall), 32'd1);
      chk("b_acc4",  32'(sb_if.issue_accept), 32'd0);
      @(negedge clk); wb(1, 7); #1;
      chk("b_stall_wb", 32'(sb_if.reg_stall), 32'd1);
      @(negedge clk); wb(0, 0); #1;
      chk("b_infl2", 32'(sb_if.inflight), 32'd2);
      chk("b_acc5",  32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); sb_if.issue_valid = 1'b0; wb(1, 7); #1;
      chk("b_infl3b", 32'(sb_if.inflight), 32'd3);
      repeat (2) @(negedge clk);
      @(negedge clk); wb(0, 0); #1;
      chk("b_infl0", 32'(sb_if.inflight), 32'd0);

      // same-cycle issue and writeback to r9
      @(negedge clk); drv(1, 0, 0, 9); #1;
      chk("c_acc1", 32'(sb_if.issue_accept), 32'd1);
      @(negedge clk); wb(1, 9); #1;
      chk("c_acc2",  32'(sb_if.issue_accept), 32'd1);
      chk("c_infl1", 32'(sb_if.inflight), 32'd1);
      @(negedge clk); sb_if.issue_valid = 1'b0; wb(0, 0); #1;
      chk("c_infl_same", 32'(sb_if.inflight), 32'd1);
      chk("c_busy9",     sb_if.busy, 32'h200);
      @(negedge clk); wb(1, 9);
      @(negedge clk); wb(0, 0); #1;
      chk("c_infl0", 32'(sb_if.inflight), 32'd0);

      // underflow error, then writeback to r0 is ignored
      @(negedge clk); wb(1, 12); #1;
      chk("d_err_pre", 32'(sb_if.err), 32'd0);
      @(negedge clk); wb(1, 0); #1;
      chk("d_err",  32'(sb_if.err), 32'd1);
      chk("d_infl", 32'(sb_if.inflight), 32'd0);
      @(negedge clk); wb(0, 0); #1;
      chk("d_wb0_busy", sb_if.busy, 32'd0);

      // flush with five writes pending and a competing issue
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); drv(1, 0, 0, 5'(rds[i])); #1;
         chk("e_fill_acc", 32'(sb_if.issue_accept), 32'd1);
      end
      @(negedge clk); drv(1, 0, 0, 3); sb_if.flush = 1'b1; #1;
      chk("e_infl5",  32'(sb_if.inflight), 32'd5);
      chk("e_busy",   sb_if.busy, 32'h11E);
      chk("e_acc",    32'(sb_if.issue_accept), 32'd0);
      @(negedge clk); idle(); #1;
      chk("e_infl0",  32'(sb_if.inflight), 32'd0);
      chk("e_busy0",  sb_if.busy, 32'd0);
      chk("e_err",    32'(sb_if.err), 32'd1);

      // drain with two writes outstanding
      @(negedge clk); drv(1, 0, 0, 10);
      @(negedge clk); drv(1, 0, 0, 11);
      @(negedge clk); sb_if.issue_valid = 1'b0; sb_if.drain_req = 1'b1; #1;
      chk("f_infl2", 32'(sb_if.inflight), 32'd2);
      @(negedge clk); drv(1, 0, 0, 0); wb(1, 10); #1;
      chk("f_stall", 32'(sb_if.reg_stall), 32'd1);
      chk("f_acc1",  32'(sb_if.issue_accept), 32'd0);
      chk("f_done1", 32'(sb_if.drain_done), 32'd0);
      @(negedge clk); wb(1, 11); #1;
      chk("f_infl1", 32'(sb_if.inflight), 32'd1);
      chk("f_acc2",  32'(sb_if.issue_accept), 32'd0);
      chk("f_done2", 32'(sb_if.drain_done), 32'd0);
      @(negedge clk); wb(0, 0); #1;
      chk("f_done3", 32'(sb_if.drain_done), 32'd1);
      chk("f_infl0", 32'(sb_if.inflight), 32'd0);
      chk("f_acc3",  32'(sb_if.issue_accept), 32'd0);
      @(negedge clk); #1;
      chk("f_done4", 32'(sb_if.drain_done), 32'd0);
      chk("f_acc4",  32'(sb_if.issue_accept), 32'd0);
      sb_if.drain_req = 1'b0;
      @(negedge clk); #1;
      chk("f_run_acc", 32'(sb_if.issue_accept), 32'd1);
      chk("f_done5",   32'(sb_if.drain_done), 32'd0);

      // drain with nothing outstanding
      @(negedge clk); idle(); sb_if.drain_req = 1'b1;
      @(negedge clk); #1;
      chk("g_done0", 32'(sb_if.drain_done), 32'd0);
      @(negedge clk); #1;
      chk("g_done1", 32'(sb_if.drain_done), 32'd1);
      sb_if.drain_req = 1'b0;
      @(negedge clk); #1;
      chk("g_done2", 32'(sb_if.drain_done), 32'd0);

      // reset in the middle of a drain
      @(negedge clk); drv(1, 0, 0, 14);
      @(negedge clk); idle(); sb_if.drain_req = 1'b1; #1;
      chk("h_infl1", 32'(sb_if.inflight), 32'd1);
      @(negedge clk); rst = 1'b1; #1;
      chk("h_infl0", 32'(sb_if.inflight), 32'd0);
      chk("h_busy0", sb_if.busy, 32'd0);
      chk("h_err0",  32'(sb_if.err), 32'd0);
      chk("h_done0", 32'(sb_if.drain_done), 32'd0);
      @(negedge clk); sb_if.drain_req = 1'b0; rst = 1'b0; drv(1, 0, 0, 0); #1;
      chk("h_run_acc", 32'(sb_if.issue_accept), 32'd1);
      chk("h_done1",   32'(sb_if.drain_done), 32'd0);
      @(negedge clk); idle(); #1;
      chk("h_done2",   32'(sb_if.drain_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
